// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 blocks of 4 bytes in
// front of a multi-cycle 32-bit block memory. Hits never stall; misses run WRITEBACK/FETCH.
module cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  input  logic        MEM_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state_q, state_d;
  logic        accepted_q, accepted_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [5:0]  mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic [31:0] data_q [8];
  logic [2:0]  tag_q [8];
  logic [7:0]  valid_q, dirty_q;

  logic [2:0]  index;
  logic [2:0]  tag_in;
  logic [1:0]  offset;
  logic [31:0] blk;
  logic [31:0] merged;
  logic [7:0]  lane [4];
  logic        req;
  logic        hit;
  logic        write_hit;
  logic        fill;

  assign index  = ADDRESS[4:2];
  assign tag_in = ADDRESS[7:5];
  assign offset = ADDRESS[1:0];
  assign blk    = data_q[index];
  assign req    = READ | WRITE;
  assign hit    = valid_q[index] && (tag_q[index] == tag_in);

  // Lane 0 is the low byte of the block word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi]          = blk[gi*8 +: 8];
      assign merged[gi*8 +: 8] = (offset == 2'(gi)) ? WRITEDATA : blk[gi*8 +: 8];
    end
  endgenerate

  assign READDATA  = lane[offset];
  assign BUSYWAIT  = !RESET && req && !(state_q == IDLE && hit);
  assign write_hit = WRITE && (state_q == IDLE) && hit;
  // A transfer only finishes once memory has been seen busy and then released.
  assign fill      = (state_q == FETCH) && accepted_q && !MEM_BUSYWAIT;

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

  always_comb begin
    state_d         = state_q;
    accepted_d      = accepted_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          accepted_d = 1'b0;
          if (valid_q[index] && dirty_q[index]) begin
            state_d         = WRITEBACK;
            mem_write_d     = 1'b1;
            mem_address_d   = {tag_q[index], index};
            mem_writedata_d = blk;
          end else begin
            state_d       = FETCH;
            mem_read_d    = 1'b1;
            mem_address_d = ADDRESS[7:2];
          end
        end
      end
      WRITEBACK: begin
        if (MEM_BUSYWAIT) begin
          accepted_d = 1'b1;
        end else if (accepted_q) begin
          state_d       = FETCH;
          accepted_d    = 1'b0;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = ADDRESS[7:2];
        end
      end
      FETCH: begin
        if (MEM_BUSYWAIT) begin
          accepted_d = 1'b1;
        end else if (accepted_q) begin
          state_d    = IDLE;
          accepted_d = 1'b0;
          mem_read_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        accepted_d  = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      accepted_q      <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
    end else begin
      state_q         <= state_d;
      accepted_q      <= accepted_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      if (fill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Block contents and tags are not reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill) begin
        data_q[index] <= MEM_READDATA;
        tag_q[index]  <= tag_in;
      end else if (write_hit) begin
        data_q[index] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache with a 5-cycle block memory model and a queue of
// expected load bytes popped when the stall releases.
module tb_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_BUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;

  always #5 CLK = ~CLK;

  cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA)
  );

  // Block memory model: 64 words, zeroed on reset, busy for 5 cycles per request.
  logic [31:0] mem [64];
  logic        mem_busy = 1'b0;
  logic        just_done = 1'b0;
  logic [2:0]  cnt = '0;
  logic        op_wr = 1'b0;
  logic [5:0]  op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          n_txn = 0;

  assign MEM_BUSYWAIT = mem_busy;
  assign MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if (RESET) begin
      mem_busy  <= 1'b0;
      just_done <= 1'b0;
      cnt       <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      just_done <= 1'b0;
      if (mem_busy) begin
        if (cnt == 0) begin
          mem_busy  <= 1'b0;
          just_done <= 1'b1;
          if (op_wr) mem[op_addr] <= op_wdata;
          else       mem_rdata    <= mem[op_addr];
        end else begin
          cnt <= cnt - 3'd1;
        end
      end else if (!just_done && (MEM_READ || MEM_WRITE)) begin
        mem_busy <= 1'b1;
        cnt      <= 3'd4;
        op_wr    <= MEM_WRITE;
        op_addr  <= MEM_ADDRESS;
        op_wdata <= MEM_WRITEDATA;
        n_txn    <= n_txn + 1;
      end
    end
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  int         txn0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    #1;
  endtask

  task automatic end_access();
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (BUSYWAIT !== 1'b0 && n < 40) begin
      @(negedge CLK); #1; n++;
    end
    check({tag, "_stall_release"}, {31'd0, BUSYWAIT}, 32'd0);
  endtask

  task automatic wait_mem_read(input string tag);
    int n = 0;
    while (MEM_READ !== 1'b1 && n < 40) begin
      @(negedge CLK); #1; n++;
    end
    check({tag, "_mem_read"}, {31'd0, MEM_READ}, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = sb.pop_front();
    check(tag, {24'd0, READDATA}, {24'd0, e});
    $display("read %s: data %h", tag, READDATA);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e, input string tag);
    start_access(1'b1, 1'b0, a, 8'h00);
    sb.push_back(e);
    wait_not_busy(tag);
    pop_check(tag);
    end_access();
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05; WRITEDATA = 8'h00;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("reset_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    check("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0;
    preload(6'd1, 32'h44332211);
    preload(6'd2, 32'h01020304);
    preload(6'd9, 32'hDDCCBBAA);
    preload(6'd10, 32'h55667788);
    @(negedge CLK);
    pl_en = 1'b0;

    // Cold read miss on 0x05
    start_access(1'b1, 1'b0, 8'h05, 8'h00);
    check("miss1_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check("miss1_mem_read", {31'd0, MEM_READ}, 32'd1);
    check("miss1_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("miss1_mem_address", {26'd0, MEM_ADDRESS}, 32'h01);
    sb.push_back(8'h22);
    wait_not_busy("miss1");
    pop_check("miss1");
    end_access();

    // Repeat read hits with no stall and no memory traffic
    txn0 = n_txn;
    start_access(1'b1, 1'b0, 8'h05, 8'h00);
    check("hit1_nostall", {31'd0, BUSYWAIT}, 32'd0);
    sb.push_back(8'h22);
    pop_check("hit1");
    end_access();
    check("hit1_no_traffic", n_txn, txn0);

    // Write hit then read back
    start_access(1'b0, 1'b1, 8'h05, 8'hAB);
    check("whit_nostall", {31'd0, BUSYWAIT}, 32'd0);
    end_access();
    $display("write 05 <= ab");
    do_read(8'h05, 8'hAB, "rd_after_write");

    // Dirty victim: write back index 1, then fetch word 9
    start_access(1'b1, 1'b0, 8'h25, 8'h00);
    check("wb_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check("wb_mem_write", {31'd0, MEM_WRITE}, 32'd1);
    check("wb_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("wb_mem_address", {26'd0, MEM_ADDRESS}, 32'h01);
    check("wb_mem_writedata", MEM_WRITEDATA, 32'h4433AB11);
    wait_mem_read("wb_fetch");
    check("wb_fetch_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("wb_fetch_mem_address", {26'd0, MEM_ADDRESS}, 32'h09);
    sb.push_back(8'hBB);
    wait_not_busy("wb_fetch");
    pop_check("rd_25");
    end_access();

    // Clean write miss on 0x0A
    start_access(1'b0, 1'b1, 8'h0A, 8'h7F);
    check("wmiss_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check("wmiss_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("wmiss_mem_read", {31'd0, MEM_READ}, 32'd1);
    check("wmiss_mem_address", {26'd0, MEM_ADDRESS}, 32'h02);
    wait_not_busy("wmiss");
    end_access();
    $display("write 0a <= 7f");
    txn0 = n_txn;
    do_read(8'h0A, 8'h7F, "rd_0a");
    do_read(8'h08, 8'h04, "rd_08");
    check("wmiss_hits_no_traffic", n_txn, txn0);

    // Index 2 must now be dirty: its eviction writes the merged block
    start_access(1'b1, 1'b0, 8'h2A, 8'h00);
    @(negedge CLK); #1;
    check("dirty2_mem_write", {31'd0, MEM_WRITE}, 32'd1);
    check("dirty2_mem_address", {26'd0, MEM_ADDRESS}, 32'h02);
    check("dirty2_mem_writedata", MEM_WRITEDATA, 32'h017F0304);
    sb.push_back(8'h66);
    wait_not_busy("dirty2");
    pop_check("rd_2a");
    end_access();

    // Clean eviction of index 1 refetches the written-back word 1
    start_access(1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge CLK); #1;
    check("clean1_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("clean1_mem_read", {31'd0, MEM_READ}, 32'd1);
    check("clean1_mem_address", {26'd0, MEM_ADDRESS}, 32'h01);
    sb.push_back(8'hAB);
    wait_not_busy("clean1");
    pop_check("rd_05_refetch");
    end_access();

    // Reset in the middle of a fetch
    start_access(1'b1, 1'b0, 8'h31, 8'h00);
    @(negedge CLK);
    @(negedge CLK); #1;
    check("midrst_fetching", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("midrst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    @(negedge CLK); #1;
    check("midrst_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("midrst_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    RESET = 1'b0; READ = 1'b0;
    start_access(1'b1, 1'b0, 8'h05, 8'h00);
    check("postrst_miss_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check("postrst_mem_read", {31'd0, MEM_READ}, 32'd1);
    check("postrst_mem_address", {26'd0, MEM_ADDRESS}, 32'h01);
    sb.push_back(8'h00);
    wait_not_busy("postrst");
    pop_check("rd_05_postrst");
    end_access();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
